// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush/forward controller.
// Holds the controller state type, operand-select codes and the x0 register id.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] RES_SRC_LOAD = 2'b01;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [5:0] REG_X0 = 6'd0;

    // True when a producer register feeds a consumer; x0 never matches.
    function automatic logic reg_match(logic [5:0] prod, logic [5:0] cons);
        return (prod == cons) && (prod != REG_X0);
    endfunction

endpackage

// File: rtl/forward_select_unit.sv
// Operand bypass selector for one execute-stage source register.
// The memory stage wins over writeback because it holds the younger result.
module forward_select_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [5:0] rs_E,
    input  logic [5:0] rd_M,
    input  logic       wr_M,
    input  logic [5:0] rd_W,
    input  logic       wr_W,
    output logic [1:0] fwd_sel
);

    // Pick the youngest in-flight producer of rs_E, else the register file.
    always_comb begin
        fwd_sel = FWD_RF;
        if (wr_M && reg_match(rd_M, rs_E)) begin
            fwd_sel = FWD_M;
        end else if (wr_W && reg_match(rd_W, rs_E)) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/pipe_stall_controller.sv
// Hazard controller for a five-stage pipe: memory-wait stalls with timeout,
// branch flushes, load-use bubbles, operand forwarding and a stall counter.
module pipe_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        async_reset,
    input  logic [5:0]  rs1_D,
    input  logic [5:0]  rs2_D,
    input  logic [5:0]  rs1_E,
    input  logic [5:0]  rs2_E,
    input  logic [5:0]  rd_E,
    input  logic [1:0]  result_source_E,
    input  logic        write_scalar_reg_E,
    input  logic        write_vector_reg_E,
    input  logic [5:0]  rd_M,
    input  logic        write_scalar_reg_M,
    input  logic        write_vector_reg_M,
    input  logic [5:0]  rd_W,
    input  logic        write_scalar_reg_W,
    input  logic        write_vector_reg_W,
    input  logic        branch_taken_E,
    input  logic        mem_request_M,
    input  logic        mem_ready,
    output logic        enable_F,
    output logic        enable_D,
    output logic        enable_E,
    output logic        enable_M,
    output logic        enable_W,
    output logic        flush_D,
    output logic        flush_E,
    output logic [1:0]  forward_A_E,
    output logic [1:0]  forward_B_E,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    localparam int CLOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W  = (CLOG_W > 8) ? CLOG_W : 8;
    localparam logic [CNT_W-1:0] TIMEOUT_W = CNT_W'(TIMEOUT_CYCLES);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [15:0]      stall_cycles_q, stall_cycles_d;

    logic wr_E, wr_M, wr_W;
    logic mem_stall;
    logic load_use;

    assign wr_E = write_scalar_reg_E | write_vector_reg_E;
    assign wr_M = write_scalar_reg_M | write_vector_reg_M;
    assign wr_W = write_scalar_reg_W | write_vector_reg_W;

    assign mem_stall = mem_request_M & ~mem_ready;

    assign load_use = (result_source_E == RES_SRC_LOAD) && wr_E
                    && (reg_match(rd_E, rs1_D) || reg_match(rd_E, rs2_D));

    forward_select_unit u_fwd_a (
        .rs_E    (rs1_E),
        .rd_M    (rd_M),
        .wr_M    (wr_M),
        .rd_W    (rd_W),
        .wr_W    (wr_W),
        .fwd_sel (forward_A_E)
    );

    forward_select_unit u_fwd_b (
        .rs_E    (rs2_E),
        .rd_M    (rd_M),
        .wr_M    (wr_M),
        .rd_W    (rd_W),
        .wr_W    (wr_W),
        .fwd_sel (forward_B_E)
    );

    // Pipe enables and flushes: error > memory stall > branch > load-use.
    always_comb begin
        enable_F = 1'b1;
        enable_D = 1'b1;
        enable_E = 1'b1;
        enable_M = 1'b1;
        enable_W = 1'b1;
        flush_D  = 1'b0;
        flush_E  = 1'b0;
        if (async_reset) begin
            enable_F = 1'b1;
        end else if (state_q == ST_ERROR || mem_stall) begin
            enable_F = 1'b0;
            enable_D = 1'b0;
            enable_E = 1'b0;
            enable_M = 1'b0;
            enable_W = 1'b0;
        end else if (branch_taken_E) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
        end else if (load_use) begin
            enable_F = 1'b0;
            enable_D = 1'b0;
            flush_E  = 1'b1;
        end
    end

    // Memory-wait state machine and its timeout counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_d >= TIMEOUT_W) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Sticky timeout flag and saturating stall counter.
    always_comb begin
        mem_timeout_d  = mem_timeout_q | (state_d == ST_ERROR);
        stall_cycles_d = stall_cycles_q;
        if (!enable_D && stall_cycles_q != 16'hFFFF) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    // Controller state registers.
    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_stall_controller.sv
// Scoreboard bench for pipe_stall_controller (TIMEOUT_CYCLES=4).
// Expectations are queued at drive time and compared against sampled outputs.
module tb_pipe_stall_controller;

    logic        clock = 1'b0;
    logic        async_reset;
    logic [5:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic [1:0]  result_source_E;
    logic        write_scalar_reg_E, write_vector_reg_E;
    logic        write_scalar_reg_M, write_vector_reg_M;
    logic        write_scalar_reg_W, write_vector_reg_W;
    logic        branch_taken_E, mem_request_M, mem_ready;
    logic        enable_F, enable_D, enable_E, enable_M, enable_W;
    logic        flush_D, flush_E, mem_timeout;
    logic [1:0]  forward_A_E, forward_B_E;
    logic [15:0] stall_cycles;

    int checks   = 0;
    int failures = 0;
    int exp_sc   = 0;

    string       name_q[$];
    logic [27:0] exp_q[$];
    logic [27:0] obs_q[$];

    pipe_stall_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clock              (clock),
        .async_reset        (async_reset),
        .rs1_D              (rs1_D),
        .rs2_D              (rs2_D),
        .rs1_E              (rs1_E),
        .rs2_E              (rs2_E),
        .rd_E               (rd_E),
        .result_source_E    (result_source_E),
        .write_scalar_reg_E (write_scalar_reg_E),
        .write_vector_reg_E (write_vector_reg_E),
        .rd_M               (rd_M),
        .write_scalar_reg_M (write_scalar_reg_M),
        .write_vector_reg_M (write_vector_reg_M),
        .rd_W               (rd_W),
        .write_scalar_reg_W (write_scalar_reg_W),
        .write_vector_reg_W (write_vector_reg_W),
        .branch_taken_E     (branch_taken_E),
        .mem_request_M      (mem_request_M),
        .mem_ready          (mem_ready),
        .enable_F           (enable_F),
        .enable_D           (enable_D),
        .enable_E           (enable_E),
        .enable_M           (enable_M),
        .enable_W           (enable_W),
        .flush_D            (flush_D),
        .flush_E            (flush_E),
        .forward_A_E        (forward_A_E),
        .forward_B_E        (forward_B_E),
        .mem_timeout        (mem_timeout),
        .stall_cycles       (stall_cycles)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [27:0] obs();
        return {enable_F, enable_D, enable_E, enable_M, enable_W,
                flush_D, flush_E, forward_A_E, forward_B_E,
                mem_timeout, stall_cycles};
    endfunction

    function automatic logic [27:0] mk(logic [4:0] en, logic [1:0] fl,
                                       logic [1:0] fa, logic [1:0] fb,
                                       logic tmo);
        return {en, fl, fa, fb, tmo, 16'(exp_sc)};
    endfunction

    task automatic idle();
        rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0;
        rd_E = 0; rd_M = 0; rd_W = 0;
        result_source_E = 2'b00;
        write_scalar_reg_E = 0; write_vector_reg_E = 0;
        write_scalar_reg_M = 0; write_vector_reg_M = 0;
        write_scalar_reg_W = 0; write_vector_reg_W = 0;
        branch_taken_E = 0; mem_request_M = 0; mem_ready = 0;
    endtask

    // Queue expectation, sample at negedge, then advance past the next posedge.
    task automatic step(string nm, logic [4:0] en, logic [1:0] fl,
                        logic [1:0] fa, logic [1:0] fb, logic tmo);
        name_q.push_back(nm);
        exp_q.push_back(mk(en, fl, fa, fb, tmo));
        @(negedge clock);
        obs_q.push_back(obs());
        if (!en[3] && !async_reset && exp_sc < 65535) exp_sc++;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [27:0] e, o;
        string nm;
        idle();
        async_reset = 1;
        result_source_E = 2'b01; write_scalar_reg_E = 1;
        rd_E = 6'd5; rs1_D = 6'd5;
        rd_M = 6'd5; write_scalar_reg_M = 1; rs1_E = 6'd5;
        exp_sc = 0;
        #2;
        step("rst_hazard_held", 5'b11111, 2'b00, 2'b10, 2'b00, 0);
        step("rst_second", 5'b11111, 2'b00, 2'b10, 2'b00, 0);
        async_reset = 0;
        idle();
        step("rst_release", 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        while (exp_q.size() > 0) begin
            nm = name_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", nm, o, e);
            end
        end
    endtask

    task automatic test_load_use();
        logic [27:0] e, o;
        string nm;
        idle();
        result_source_E = 2'b01; write_scalar_reg_E = 1;
        rd_E = 6'd5; rs1_D = 6'd5;
        step("lu_rs1", 5'b00111, 2'b01, 2'b00, 2'b00, 0);
        idle();
        step("lu_after", 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        result_source_E = 2'b01; write_vector_reg_E = 1;
        rd_E = 6'd32; rs2_D = 6'd32;
        step("lu_v0_rs2", 5'b00111, 2'b01, 2'b00, 2'b00, 0);
        idle();
        result_source_E = 2'b01; write_scalar_reg_E = 1;
        rd_E = 6'd0; rs1_D = 6'd0;
        step("lu_x0", 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        result_source_E = 2'b00; rd_E = 6'd5; rs1_D = 6'd5;
        step("lu_nonload", 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        result_source_E = 2'b01; write_scalar_reg_E = 0;
        step("lu_nowrite", 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        idle();
        step("lu_idle", 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        while (exp_q.size() > 0) begin
            nm = name_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", nm, o, e);
            end
        end
    endtask

    task automatic test_branch();
        logic [27:0] e, o;
        string nm;
        idle();
        branch_taken_E = 1;
        result_source_E = 2'b01; write_scalar_reg_E = 1;
        rd_E = 6'd7; rs1_D = 6'd7;
        step("br_over_lu", 5'b11111, 2'b11, 2'b00, 2'b00, 0);
        idle();
        branch_taken_E = 1;
        step("br_only", 5'b11111, 2'b11, 2'b00, 2'b00, 0);
        while (exp_q.size() > 0) begin
            nm = name_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", nm, o, e);
            end
        end
    endtask

    task automatic test_forwarding();
        logic [27:0] e, o;
        string nm;
        idle();
        rd_M = 6'd33; write_vector_reg_M = 1;
        rd_W = 6'd33; write_vector_reg_W = 1; rs1_E = 6'd33;
        step("fwd_m_over_w", 5'b11111, 2'b00, 2'b10, 2'b00, 0);
        idle();
        rd_M = 6'd0; write_scalar_reg_M = 1;
        rd_W = 6'd0; write_scalar_reg_W = 1;
        step("fwd_x0", 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        idle();
        rd_M = 6'd8; write_scalar_reg_M = 1; rs1_E = 6'd8;
        rd_W = 6'd7; write_scalar_reg_W = 1; rs2_E = 6'd7;
        step("fwd_a_m_b_w", 5'b11111, 2'b00, 2'b10, 2'b01, 0);
        idle();
        rd_M = 6'd7; rd_W = 6'd7; write_vector_reg_W = 1; rs1_E = 6'd7;
        step("fwd_m_nowrite", 5'b11111, 2'b00, 2'b01, 2'b00, 0);
        idle();
        rd_M = 6'd32; write_vector_reg_M = 1; rs2_E = 6'd32;
        step("fwd_v0", 5'b11111, 2'b00, 2'b00, 2'b10, 0);
        idle();
        while (exp_q.size() > 0) begin
            nm = name_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", nm, o, e);
            end
        end
    endtask

    task automatic test_mem_wait();
        logic [27:0] e, o;
        string nm;
        idle();
        mem_request_M = 1; mem_ready = 1;
        step("mem_zero_wait", 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        mem_ready = 0; branch_taken_E = 1;
        for (int i = 0; i < 3; i++)
            step($sformatf("mem_wait_%0d", i), 5'b00000, 2'b00, 2'b00, 2'b00, 0);
        mem_ready = 1;
        step("mem_release_br", 5'b11111, 2'b11, 2'b00, 2'b00, 0);
        idle();
        step("mem_run", 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        while (exp_q.size() > 0) begin
            nm = name_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", nm, o, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [27:0] e, o;
        string nm;
        idle();
        mem_request_M = 1; mem_ready = 0;
        for (int i = 0; i < 6; i++)
            step($sformatf("tmo_cycle_%0d", i), 5'b00000, 2'b00, 2'b00, 2'b00,
                 logic'(i == 5));
        idle();
        branch_taken_E = 1;
        rd_M = 6'd9; write_scalar_reg_M = 1; rs1_E = 6'd9;
        step("tmo_sticky_fwd", 5'b00000, 2'b00, 2'b10, 2'b00, 1);
        #2;
        async_reset = 1;
        exp_sc = 0;
        #1;
        name_q.push_back("tmo_reset_now");
        exp_q.push_back(mk(5'b11111, 2'b00, 2'b10, 2'b00, 0));
        obs_q.push_back(obs());
        #2;
        async_reset = 0;
        idle();
        @(posedge clock);
        #1;
        step("tmo_after_reset", 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        while (exp_q.size() > 0) begin
            nm = name_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", nm, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [27:0] e, o;
        string nm;
        idle();
        mem_request_M = 1; mem_ready = 0;
        step("mid_wait_0", 5'b00000, 2'b00, 2'b00, 2'b00, 0);
        step("mid_wait_1", 5'b00000, 2'b00, 2'b00, 2'b00, 0);
        #2;
        async_reset = 1;
        exp_sc = 0;
        #1;
        name_q.push_back("mid_reset_now");
        exp_q.push_back(mk(5'b11111, 2'b00, 2'b00, 2'b00, 0));
        obs_q.push_back(obs());
        mem_request_M = 0;
        #2;
        async_reset = 0;
        @(posedge clock);
        #1;
        mem_request_M = 1;
        for (int i = 0; i < 4; i++)
            step($sformatf("mid_rewait_%0d", i), 5'b00000, 2'b00, 2'b00, 2'b00, 0);
        idle();
        step("mid_cnt_cleared", 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        step("mid_run", 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        while (exp_q.size() > 0) begin
            nm = name_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", nm, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_forwarding();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
